// File: rtl/scaler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scaler_ctrl
// Description : Ping-pong tile buffer controller with 2-D pixel-replicating
//               readout. Optional macro SCALER_CTRL_FRAME_REPEAT_EN replays
//               the current bank when the next tile is not ready.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_ctrl #(
  parameter int SRC_W = 32,
  parameter int SRC_H = 32,
  parameter int HREP  = 20,
  parameter int VREP  = 15
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [7:0] i_wr_data,
  output logic       o_buf_we,
  output logic       o_buf_wbank,
  output logic [9:0] o_buf_waddr,
  output logic [7:0] o_buf_wdata,
  output logic       o_buf_re,
  output logic       o_buf_rbank,
  output logic [9:0] o_buf_raddr,
  input  logic [7:0] i_buf_rdata,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_sof,
  output logic       o_out_eol,
  output logic       o_busy
);

  localparam int c_AW   = 10;
  localparam int c_CW   = $clog2(SRC_W);
  localparam int c_RW   = $clog2(SRC_H);
  localparam int c_HW   = $clog2(HREP);
  localparam int c_VW   = $clog2(VREP);
  localparam int c_NPIX = SRC_W * SRC_H;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_wbank;
  logic              r_rbank;
  logic [c_AW-1:0]   r_wcount;
  logic              r_wfull;
  logic              r_wait;
  logic [c_HW-1:0]   r_hrep;
  logic [c_CW-1:0]   r_col;
  logic [c_VW-1:0]   r_vrep;
  logic [c_RW-1:0]   r_row;
  logic              r_pend;
  logic              r_pend_sof;
  logic              r_pend_eol;
  logic [1:0][9:0]   r_fmem;
  logic              r_fwp;
  logic              r_frp;
  logic [1:0]        r_fcnt;

  logic              w_wr_acc;
  logic              w_wlast;
  logic              w_full_now;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_re;
  logic              w_hend;
  logic              w_cend;
  logic              w_vend;
  logic              w_rend;
  logic              w_first;
  logic              w_fend;

  assign o_wr_ready = (r_state == S_FILL) | ((r_state == S_RUN) & ~r_wfull);
  assign w_wr_acc   = i_wr_valid & o_wr_ready;
  assign w_wlast    = w_wr_acc & (r_wcount == c_AW'(c_NPIX - 1));
  assign w_full_now = r_wfull | w_wlast;

  // Occupancy the FIFO will have after this edge if no read is issued now.
  assign w_pop = (r_fcnt != 2'd0) & i_out_ready;
  assign w_occ = r_fcnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_re  = (r_state == S_RUN) & ~r_wait & (w_occ < 2'd2);

  assign w_hend  = (r_hrep == c_HW'(HREP - 1));
  assign w_cend  = (r_col  == c_CW'(SRC_W - 1));
  assign w_vend  = (r_vrep == c_VW'(VREP - 1));
  assign w_rend  = (r_row  == c_RW'(SRC_H - 1));
  assign w_first = (r_hrep == '0) & (r_col == '0) & (r_vrep == '0) & (r_row == '0);
  assign w_fend  = w_re & w_hend & w_cend & w_vend & w_rend;

  assign o_buf_we    = w_wr_acc;
  assign o_buf_wbank = r_wbank;
  assign o_buf_waddr = r_wcount;
  assign o_buf_wdata = w_wr_acc ? i_wr_data : 8'd0;
  assign o_buf_re    = w_re;
  assign o_buf_rbank = r_rbank;
  assign o_buf_raddr = c_AW'({r_row, r_col});

  assign o_out_valid = (r_fcnt != 2'd0);
  assign o_out_data  = r_fmem[r_frp][7:0];
  assign o_out_sof   = o_out_valid & r_fmem[r_frp][9];
  assign o_out_eol   = o_out_valid & r_fmem[r_frp][8];
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_wcount   <= '0;
      r_wfull    <= 1'b0;
      r_wait     <= 1'b0;
      r_hrep     <= '0;
      r_col      <= '0;
      r_vrep     <= '0;
      r_row      <= '0;
      r_pend     <= 1'b0;
      r_pend_sof <= 1'b0;
      r_pend_eol <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wcount <= w_wlast ? '0 : r_wcount + c_AW'(1);
      end
      if (w_wlast) begin
        r_wfull <= 1'b1;
      end

      r_pend     <= w_re;
      r_pend_sof <= w_re & w_first;
      r_pend_eol <= w_re & w_hend & w_cend;

      // hrep innermost, then col, vrep, row; all wrap to zero at frame end.
      if (w_re) begin
        if (w_hend) begin
          r_hrep <= '0;
          if (w_cend) begin
            r_col <= '0;
            if (w_vend) begin
              r_vrep <= '0;
              r_row  <= w_rend ? '0 : r_row + c_RW'(1);
            end else begin
              r_vrep <= r_vrep + c_VW'(1);
            end
          end else begin
            r_col <= r_col + c_CW'(1);
          end
        end else begin
          r_hrep <= r_hrep + c_HW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_FILL;
            r_wbank  <= 1'b0;
            r_wcount <= '0;
            r_wfull  <= 1'b0;
            r_wait   <= 1'b0;
            r_hrep   <= '0;
            r_col    <= '0;
            r_vrep   <= '0;
            r_row    <= '0;
          end
        end
        S_FILL: begin
          if (w_wlast) begin
            r_state <= S_RUN;
            r_rbank <= r_wbank;
            r_wbank <= ~r_wbank;
            r_wfull <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_wait) begin
            if (!i_start) begin
              r_state <= S_DRAIN;
              r_wait  <= 1'b0;
            end else if (w_full_now) begin
              r_rbank  <= r_wbank;
              r_wbank  <= ~r_wbank;
              r_wcount <= '0;
              r_wfull  <= 1'b0;
              r_wait   <= 1'b0;
            end
          end else if (w_fend) begin
            if (!i_start) begin
              r_state <= S_DRAIN;
            end else if (w_full_now) begin
              r_rbank  <= r_wbank;
              r_wbank  <= ~r_wbank;
              r_wcount <= '0;
              r_wfull  <= 1'b0;
            end else begin
`ifdef SCALER_CTRL_FRAME_REPEAT_EN
              r_wait <= 1'b0;
`else
              r_wait <= 1'b1;
`endif
            end
          end
        end
        S_DRAIN: begin
          if ((r_fcnt == 2'd0) && !r_pend) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; sof/eol ride along with the pixel.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fmem <= '0;
      r_fwp  <= 1'b0;
      r_frp  <= 1'b0;
      r_fcnt <= 2'd0;
    end else begin
      if (r_pend) begin
        r_fmem[r_fwp] <= {r_pend_sof, r_pend_eol, i_buf_rdata};
        r_fwp         <= ~r_fwp;
      end
      if (w_pop) begin
        r_frp <= ~r_frp;
      end
      r_fcnt <= w_occ;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scaler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scaler_ctrl
// Description : Directed self-checking bench for scaler_ctrl on a reduced
//               4x4 tile with 3x/2x replication (96 pixels per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler_ctrl;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int HR    = 3;
  localparam int VR    = 2;
  localparam int NPIX  = W * H;
  localparam int LINE  = W * HR;
  localparam int FRAME = LINE * H * VR;
`ifdef SCALER_CTRL_FRAME_REPEAT_EN
  localparam int FC = 3;
`else
  localparam int FC = 2;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_start = 1'b0;
  logic       i_wr_valid = 1'b0;
  logic       o_wr_ready;
  logic [7:0] i_wr_data = 8'd0;
  logic       o_buf_we;
  logic       o_buf_wbank;
  logic [9:0] o_buf_waddr;
  logic [7:0] o_buf_wdata;
  logic       o_buf_re;
  logic       o_buf_rbank;
  logic [9:0] o_buf_raddr;
  logic [7:0] i_buf_rdata;
  logic       o_out_valid;
  logic       i_out_ready = 1'b1;
  logic [7:0] o_out_data;
  logic       o_out_sof;
  logic       o_out_eol;
  logic       o_busy;

  scaler_ctrl #(.SRC_W(W), .SRC_H(H), .HREP(HR), .VREP(VR)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_buf_we(o_buf_we), .o_buf_wbank(o_buf_wbank), .o_buf_waddr(o_buf_waddr),
    .o_buf_wdata(o_buf_wdata), .o_buf_re(o_buf_re), .o_buf_rbank(o_buf_rbank),
    .o_buf_raddr(o_buf_raddr), .i_buf_rdata(i_buf_rdata),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_sof(o_out_sof), .o_out_eol(o_out_eol), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // External two-bank buffer: one-cycle read latency.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (o_buf_we) mem[{o_buf_wbank, o_buf_waddr}] <= o_buf_wdata;
    if (o_buf_re) i_buf_rdata <= mem[{o_buf_rbank, o_buf_raddr}];
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   wr_en = 0;
  int   wr_idx = 0;
  int   wr_base = 0;
  int   exp_wbank = 0;
  int   rdy_mode = 1;
  int   exp_q[$];
  int   exp_idx = 0;
  int   frames_done = 0;
  int   last_wr_cyc = 0;
  int   last_out_cyc = 0;
  int   first_re_cyc = -1;
  int   first_valid_cyc = -1;
  bit   prev_stall = 0;
  logic [7:0] prev_data = 8'd0;
  bit   bub_en = 0;
  bit   seen_out = 0;
  int   bubbles = 0;
  int   a_last = 0;

  function automatic logic [7:0] pix(input int base, input int idx);
    return 8'(base + (idx / W) * 8 + (idx % W));
  endfunction

  function automatic logic [7:0] exp_pix(input int base, input int k);
    int col;
    int row;
    col = (k % LINE) / HR;
    row = (k / LINE) / VR;
    return 8'(base + row * 8 + col);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_ready"}, o_wr_ready, 0);
    chk({tag, "_buf_we"}, o_buf_we, 0);
    chk({tag, "_buf_re"}, o_buf_re, 0);
    chk({tag, "_wbank"}, o_buf_wbank, 0);
    chk({tag, "_rbank"}, o_buf_rbank, 0);
    chk({tag, "_waddr"}, o_buf_waddr, 0);
    chk({tag, "_raddr"}, o_buf_raddr, 0);
    chk({tag, "_wdata"}, o_buf_wdata, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_out_data"}, o_out_data, 0);
    chk({tag, "_out_sof"}, o_out_sof, 0);
    chk({tag, "_out_eol"}, o_out_eol, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic tick();
    int base;
    @(posedge clk);
    #1;
    i_wr_valid  = wr_en && (wr_idx < NPIX);
    i_wr_data   = pix(wr_base, wr_idx);
    i_out_ready = (rdy_mode == 1) || (rdy_mode == 2 && (cyc % 2) == 0);
    @(negedge clk);
    cyc++;
    if (first_re_cyc < 0 && o_buf_re) first_re_cyc = cyc;
    if (first_valid_cyc < 0 && o_out_valid) first_valid_cyc = cyc;
    if (prev_stall) begin
      chk("stall_valid", o_out_valid, 1);
      chk("stall_data", o_out_data, prev_data);
    end
    prev_stall = o_out_valid && !i_out_ready;
    prev_data  = o_out_data;
    if (bub_en && seen_out && !o_out_valid) bubbles++;
    if (i_wr_valid && o_wr_ready) begin
      chk("wr_we", o_buf_we, 1);
      chk("wr_addr", o_buf_waddr, wr_idx);
      chk("wr_data", o_buf_wdata, pix(wr_base, wr_idx));
      chk("wr_bank", o_buf_wbank, exp_wbank);
      wr_idx++;
      last_wr_cyc = cyc;
    end
    if (o_out_valid && i_out_ready) begin
      seen_out = 1;
      last_out_cyc = cyc;
      chk("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        base = exp_q[0];
        chk("out_data", o_out_data, exp_pix(base, exp_idx));
        chk("out_sof", o_out_sof, exp_idx == 0);
        chk("out_eol", o_out_eol, (exp_idx % LINE) == LINE - 1);
        exp_idx++;
        if (exp_idx == FRAME) begin
          exp_idx = 0;
          frames_done++;
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    // Power-on reset
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) i_rst_n = 1'b1;
    tick();
    chk("idle_busy", o_busy, 0);
    chk("idle_wr_ready", o_wr_ready, 0);

    // Tile A fill, then tile B written during frame 1; back-to-back frames
    i_start = 1'b1;
    wr_en = 1; wr_base = 0; wr_idx = 0; exp_wbank = 0; rdy_mode = 1;
    exp_q.push_back(0);
    for (int i = 0; i < 100 && wr_idx < NPIX; i++) tick();
    chk("fill_timeout", wr_idx, NPIX);
    a_last = last_wr_cyc;
    wr_base = 128; wr_idx = 0; exp_wbank = 1; bub_en = 1;
    exp_q.push_back(128);
    for (int i = 0; i < 500 && frames_done < 2; i++) tick();
    chk("frame2_timeout", frames_done, 2);
    bub_en = 0;
    chk("no_bubbles", bubbles, 0);
    chk("first_re_latency", first_re_cyc, a_last + 1);
    chk("first_valid_latency", first_valid_cyc, a_last + 3);

    // Writer idle at frame 2 end
    wr_en = 0;
`ifdef SCALER_CTRL_FRAME_REPEAT_EN
    exp_q.push_back(128);
`endif
    for (int i = 0; i < 40; i++) tick();
`ifndef SCALER_CTRL_FRAME_REPEAT_EN
    chk("wait_no_valid", o_out_valid, 0);
    chk("wait_frames", frames_done, 2);
`endif

    // Tile C with out_ready toggling; start dropped mid-frame
    exp_q.push_back(64);
    wr_base = 64; wr_idx = 0; wr_en = 1; exp_wbank = 0; rdy_mode = 2;
    for (int i = 0; i < 1500 && !(frames_done == FC && exp_idx >= 40); i++) tick();
    chk("midframe_timeout", (frames_done == FC) && (exp_idx >= 40), 1);
    i_start = 1'b0;
    for (int i = 0; i < 500 && o_busy; i++) tick();
    chk("drain_timeout", o_busy, 0);
    chk("busy_drop_cycle", cyc, last_out_cyc + 2);
    chk("drain_wr_ready", o_wr_ready, 0);
    chk("drain_frames", frames_done, FC + 1);
    chk("drain_queue_empty", exp_q.size(), 0);

    // Restart, then asynchronous reset mid-frame
    i_start = 1'b1; rdy_mode = 1;
    wr_base = 0; wr_idx = 0; wr_en = 1; exp_wbank = 0;
    exp_q.push_back(0);
    for (int i = 0; i < 500 && !(frames_done == FC + 1 && exp_idx >= 20 && o_out_valid); i++) tick();
    chk("prereset_timeout", (exp_idx >= 20) && o_out_valid, 1);
    @(posedge clk);
    #2 i_rst_n = 1'b0;
    wr_en = 0; i_wr_valid = 1'b0;
    #1 check_reset("async");
    exp_q.delete();
    exp_idx = 0; prev_stall = 0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    // Recovery frame from a fresh tile
    exp_q.push_back(96);
    wr_base = 96; wr_idx = 0; wr_en = 1; exp_wbank = 0;
    for (int i = 0; i < 20 && wr_idx == 0; i++) tick();
    chk("restart_fill", wr_idx > 0, 1);
    i_start = 1'b0;
    for (int i = 0; i < 600 && !(frames_done == FC + 2 && !o_busy); i++) tick();
    chk("restart_frames", frames_done, FC + 2);
    chk("restart_idle", o_busy, 0);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scaler_ctrl.md
# scaler_ctrl

Ping-pong frame-buffer controller and readout sequencer for the ISP scaler path. It accepts a 32x32 source tile as a row-major 8-bit pixel stream and writes it into one bank of an external two-bank buffer. At the same time it scans the other bank with 20x horizontal and 15x vertical pixel replication, producing a 640x480 stream for the display side. It arbitrates buffer ownership between writer and reader and swaps banks only at frame boundaries.

## Interface
- SRC_W, 32, source columns per tile
- SRC_H, 32, source rows per tile
- HREP, 20, horizontal replication factor
- VREP, 15, vertical replication factor
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level enable; sampled in IDLE and at output-frame end
- wr_valid  in  1  source pixel valid
- wr_ready  out  1  source pixel accepted when wr_valid & wr_ready
- wr_data  in  8  source pixel
- buf_we  out  1  buffer write strobe
- buf_wbank  out  1  bank being written
- buf_waddr  out  10  write address {row[4:0],col[4:0]}
- buf_wdata  out  8  write data
- buf_re  out  1  buffer read strobe
- buf_rbank  out  1  bank being read
- buf_raddr  out  10  read address {row,col}
- buf_rdata  in  8  read data, valid the cycle after buf_re
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_data  out  8  output pixel
- out_sof  out  1  first pixel of output frame (with out_valid)
- out_eol  out  1  last pixel of output line (with out_valid)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: wr_ready=0, no reads. start=1 -> FILL, wbank=0, write count 0.
- FILL: wr_ready=1; each accepted pixel gives buf_we=1, buf_waddr=count, buf_wdata=wr_data, count+1. At count 1023 accepted -> RUN, rbank=wbank, wbank flips, count cleared.
- RUN: writer fills wbank (wr_ready=0 once bank full, 1024 pixels held). Reader scans rbank: counters hrep 0..HREP-1, col 0..SRC_W-1, vrep 0..VREP-1, row 0..SRC_H-1, hrep innermost; buf_raddr={row,col}.
- Frame end = read issued with row=31, vrep=14, col=31, hrep=19. At that edge: if write bank full, swap banks (rbank<=wbank, wbank flips, write count 0), same cycle. Otherwise see Configuration.
- At frame end with start=0 -> DRAIN: no new reads, wr_ready=0; when output FIFO empty -> IDLE. An incompletely written bank is discarded.
- Output: 2-entry FIFO. Read issued only when occupancy + in-flight read < 2 and out_ready/space permits. out_sof/out_eol travel with data through the FIFO.
- Simultaneous wr accept of pixel 1023 and reader frame end: swap occurs; the newly full bank is read next frame.

## Timing
- Reset values: wr_ready=0, buf_we=0, buf_re=0, buf_wbank=0, buf_rbank=0, addresses 0, buf_wdata=0, out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0; state IDLE.
- Write path: buf_we asserted combinationally in the same cycle as wr_valid & wr_ready (no latency).
- Read latency: entering RUN at edge N -> buf_re at cycle N, out_valid at cycle N+2, first pixel with out_sof=1.
- out_ready held high: one pixel per cycle sustained, 307200 pixels per frame, no bubbles across swaps.
- out_valid, out_data stable while out_valid & !out_ready.
- Reset asserted mid-frame: all state cleared immediately; FIFO contents dropped.

## Configuration
- SCALER_CTRL_FRAME_REPEAT_EN defined: at frame end with write bank not full, reader restarts on the same rbank (previous frame repeated); output stream never stalls on the writer.
- Undefined: at frame end with write bank not full, reader issues no reads until the bank is full; then swap and continue. out_valid drops once the FIFO drains.

## Test plan
- Reset, start=1, stream 1024 pixels of value row*8+col -> first output pixel 0 with out_sof, each source pixel repeated 20 times per line, each line repeated 15 times, 307200 outputs.
- Frame with out_ready toggling 1/0 every cycle -> no pixel lost or duplicated, out_data stable during stall, count 307200.
- Second tile written before frame 1 ends -> swap at frame end, frame 2 first pixel = tile-2 pixel (0,0), no gap with out_ready=1.
- Writer idle during frame 2 -> with macro: frame 2 repeats tile 1; without: out_valid=0 after drain until tile 2 completes, then resumes with out_sof.
- start=0 mid-frame -> current frame completes, busy=0 two cycles after last accept, wr_ready=0.
- rst low mid-frame while out_valid=1 -> all outputs at reset values asynchronously; restart yields correct frame from out_sof.
